alu_ctrl_6502: RTL and testbench

ALU_CTRL_6502 -- requirements
Module: alu_ctrl_6502

---
 rtl/alu_6502_pkg.sv | 55 +++++
 rtl/alu_6502.sv | 25 ++
 rtl/alu_ctrl_6502.sv | 156 +++++++++++++++
 tb/tb_alu_ctrl_6502.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_6502_pkg.sv
// Shared types and constants for the 6502 ALU controller: op codes, ALU modes,
// flag positions and the per-op flag-update mask.
package alu_6502_pkg;

  typedef enum logic [3:0] {
    OP_ORA = 4'd0,
    OP_AND = 4'd1,
    OP_EOR = 4'd2,
    OP_ADC = 4'd3,
    OP_SBC = 4'd4,
    OP_CMP = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_ASL = 4'd8,
    OP_LSR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} ctrl_state_t;

  localparam logic [2:0] ALU_ORA = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_EOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SHL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_ROR;
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op >= OP_ASL) && (op <= OP_ROR);
  endfunction

  // {N,V,Z,C} bits each op is allowed to update
  function automatic logic [3:0] op_mask(input logic [3:0] op);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_ORA, OP_AND, OP_EOR, OP_INC, OP_DEC: m = 4'b1010;
      OP_ADC, OP_SBC:                         m = 4'b1111;
      OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: m = 4'b1011;
      default:                                m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_6502.sv
// Combinational 6502-style ALU pass. Bit 8 of a is carry-in, bit 8 of r is
// carry-out; shifts move bit 8 through the byte as a 9-bit ring segment.
module alu_6502
  import alu_6502_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [8:0] a,
  input  logic [7:0] b,
  output logic [8:0] r
);

  always_comb begin
    r = 9'h000;
    case (mode)
      ALU_ORA: r = {1'b0, a[7:0] | b};
      ALU_AND: r = {1'b0, a[7:0] & b};
      ALU_EOR: r = {1'b0, a[7:0] ^ b};
      ALU_ADD: r = {1'b0, a[7:0]} + {1'b0, b} + {8'h00, a[8]};
      ALU_SHL: r = {a[7:0], a[8]};
      ALU_SHR: r = {a[0], a[8], a[7:1]};
      default: r = 9'h000;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_6502.sv
// Request/response controller around one alu_6502 instance. Non-shift ops take
// a single ALU pass, shifts take req_cnt+1 passes through a working register.
module alu_ctrl_6502
  import alu_6502_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [2:0] req_cnt,
  input  logic       req_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic [3:0] rsp_mask,
  output logic       rsp_write,
  output logic       rsp_err
);

  ctrl_state_t state_q, state_d;

  logic [3:0] op_r;
  logic [7:0] b_r;
  logic [2:0] cnt_r;
  logic [7:0] work_r;
  logic       work_c;
  logic       v_r;
  logic [2:0] step_q;

  logic       accept, last_step, load_rsp, legal;
  logic [2:0] alu_mode;
  logic [8:0] alu_a, alu_r;
  logic [7:0] alu_b;
  logic       c_next, v_next;
  logic [3:0] flags_all, mask;

  assign legal     = op_legal(op_r);
  assign mask      = op_mask(op_r);
  assign accept    = req_valid & req_ready;
  assign last_step = (step_q == (op_is_shift(op_r) ? cnt_r : 3'd0));
  // response registers are filled on the first RESP cycle, giving one
  // registered stage between the last ALU pass and rsp_valid
  assign load_rsp  = (state_q == ST_RESP) & ~rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_EXEC;
      end
      ST_EXEC: if (last_step) state_d = ST_RESP;
      ST_RESP: if (rsp_valid & rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // operand steering; inputs a mode does not consume are left as don't-care
  always_comb begin
    alu_mode = ALU_ORA;
    alu_a    = {1'bx, work_r};
    alu_b    = 8'bx;
    case (op_r)
      OP_ORA: begin alu_mode = ALU_ORA; alu_b = b_r; end
      OP_AND: begin alu_mode = ALU_AND; alu_b = b_r; end
      OP_EOR: begin alu_mode = ALU_EOR; alu_b = b_r; end
      OP_ADC: begin alu_mode = ALU_ADD; alu_a = {work_c, work_r}; alu_b = b_r;   end
      OP_SBC: begin alu_mode = ALU_ADD; alu_a = {work_c, work_r}; alu_b = ~b_r;  end
      OP_CMP: begin alu_mode = ALU_ADD; alu_a = {1'b1, work_r};   alu_b = ~b_r;  end
      OP_INC: begin alu_mode = ALU_ADD; alu_a = {1'b0, work_r};   alu_b = 8'h01; end
      OP_DEC: begin alu_mode = ALU_ADD; alu_a = {1'b0, work_r};   alu_b = 8'hFF; end
      OP_ASL: begin alu_mode = ALU_SHL; alu_a = {1'b0, work_r};   end
      OP_ROL: begin alu_mode = ALU_SHL; alu_a = {work_c, work_r}; end
      OP_LSR: begin alu_mode = ALU_SHR; alu_a = {1'b0, work_r};   end
      OP_ROR: begin alu_mode = ALU_SHR; alu_a = {work_c, work_r}; end
      default: ;
    endcase
  end

  alu_6502 u_alu (
    .mode (alu_mode),
    .a    (alu_a),
    .b    (alu_b),
    .r    (alu_r)
  );

  always_comb begin
    // ASL/LSR hold the carry path at zero on every step
    c_next = ((op_r == OP_ASL) || (op_r == OP_LSR)) ? 1'b0 : alu_r[8];
    v_next = 1'b0;
    if ((op_r == OP_ADC) || (op_r == OP_SBC))
      v_next = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
    flags_all         = 4'b0000;
    flags_all[FLAG_N] = work_r[7];
    flags_all[FLAG_V] = v_r;
    flags_all[FLAG_Z] = (work_r == 8'h00);
    flags_all[FLAG_C] = work_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 4'h0;
      b_r        <= 8'h00;
      cnt_r      <= 3'd0;
      work_r     <= 8'h00;
      work_c     <= 1'b0;
      v_r        <= 1'b0;
      step_q     <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_flags  <= 4'h0;
      rsp_mask   <= 4'h0;
      rsp_write  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        op_r   <= req_op;
        b_r    <= req_b;
        cnt_r  <= req_cnt;
        work_r <= req_a;
        work_c <= req_carry;
        v_r    <= 1'b0;
        step_q <= 3'd0;
      end else if (state_q == ST_EXEC) begin
        step_q <= step_q + 3'd1;
        if (legal) begin
          work_r <= alu_r[7:0];
          work_c <= c_next;
          v_r    <= v_next;
        end
      end

      if (load_rsp) begin
        rsp_valid  <= 1'b1;
        rsp_result <= work_r;
        rsp_flags  <= flags_all & mask;
        rsp_mask   <= mask;
        rsp_write  <= legal && (op_r != OP_CMP);
        rsp_err    <= ~legal;
      end else if (rsp_valid & rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_6502.sv
// Self-checking bench for alu_ctrl_6502: directed vectors, randomized ops
// against an arithmetic reference model, response hold and mid-op reset.
module tb_alu_ctrl_6502;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = 4'h0;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [2:0] req_cnt = 3'd0;
  logic       req_carry = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] rsp_mask;
  logic       rsp_write;
  logic       rsp_err;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] T_ADC = 4'd3, T_SBC = 4'd4, T_CMP = 4'd5, T_INC = 4'd6,
                         T_DEC = 4'd7, T_ASL = 4'd8, T_ROL = 4'd10, T_ROR = 4'd11;

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    logic [3:0] m;
    logic       w;
    logic       e;
    int         lat;
  } exp_t;

  always #5 clk = ~clk;

  alu_ctrl_6502 dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cnt    (req_cnt),
    .req_carry  (req_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_mask   (rsp_mask),
    .rsp_write  (rsp_write),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic and 9-bit rotation
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] cnt, input logic c);
    exp_t e;
    int ia, ib, ic, sa, sb, sv, s, t, r9;
    logic cy, v;
    ia = int'(a); ib = int'(b); ic = int'(c);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    s  = int'(cnt) + 1;
    cy = 1'b0; v = 1'b0; t = 0; r9 = 0;
    e.m = 4'b0000; e.w = 1'b1; e.e = 1'b0;
    case (op)
      4'd0: begin t = ia | ib; e.m = 4'b1010; end
      4'd1: begin t = ia & ib; e.m = 4'b1010; end
      4'd2: begin t = ia ^ ib; e.m = 4'b1010; end
      4'd3: begin
        t = ia + ib + ic; cy = (t > 255);
        sv = sa + sb + ic; v = (sv > 127) || (sv < -128); e.m = 4'b1111;
      end
      4'd4: begin
        t = ia - ib - (1 - ic); cy = (t >= 0);
        sv = sa - sb - (1 - ic); v = (sv > 127) || (sv < -128); e.m = 4'b1111;
      end
      4'd5: begin t = ia - ib; cy = (t >= 0); e.m = 4'b1011; e.w = 1'b0; end
      4'd6: begin t = ia + 1; e.m = 4'b1010; end
      4'd7: begin t = ia - 1; e.m = 4'b1010; end
      4'd8: begin t = ia << s; e.m = 4'b1011; end
      4'd9: begin t = ia >> s; e.m = 4'b1011; end
      4'd10: begin
        r9 = ic * 256 + ia;
        r9 = ((r9 << s) | (r9 >> (9 - s))) & 511;
        t = r9; cy = r9[8]; e.m = 4'b1011;
      end
      4'd11: begin
        r9 = ic * 256 + ia;
        r9 = ((r9 >> s) | (r9 << (9 - s))) & 511;
        t = r9; cy = r9[8]; e.m = 4'b1011;
      end
      default: begin t = ia; e.w = 1'b0; e.e = 1'b1; end
    endcase
    e.r   = t[7:0];
    e.f   = {e.r[7], v, (e.r == 8'h00), cy} & e.m;
    e.lat = (op >= 4'd8 && op <= 4'd11) ? 2 + int'(cnt) : 2;
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] cnt, input logic c, input int hold,
                        output logic [7:0] o_r, output logic [3:0] o_f);
    exp_t e;
    int k;
    e = model(op, a, b, cnt, c);
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cnt = cnt; req_carry = c;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_op = 4'($urandom);
    req_cnt = 3'($urandom); req_carry = 1'($urandom);
    check("ready_busy", req_ready, 0);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    check("latency", k, e.lat);
    check("result", rsp_result, e.r);
    check("flags", rsp_flags, e.f);
    check("mask", rsp_mask, e.m);
    check("write", rsp_write, e.w);
    check("err", rsp_err, e.e);
    o_r = rsp_result;
    o_f = rsp_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, e.r);
      check("hold_flags", rsp_flags, e.f);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("keep_result", rsp_result, e.r);
  endtask

  initial begin
    logic [7:0] dr;
    logic [3:0] df;
    int seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_result", rsp_result, 0);
    check("rst_flags", {rsp_flags, rsp_mask}, 0);
    check("rst_wr_err", {rsp_write, rsp_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1);

    run_op(T_ADC, 8'h50, 8'h50, 3'd0, 1'b0, 0, dr, df);
    check("adc_res", dr, 8'hA0);
    check("adc_nvzc", df, 4'b1100);
    run_op(T_SBC, 8'h00, 8'h01, 3'd0, 1'b1, 1, dr, df);
    check("sbc_res", dr, 8'hFF);
    check("sbc_nvzc", df, 4'b1000);
    run_op(T_CMP, 8'h42, 8'h42, 3'd0, 1'b0, 0, dr, df);
    check("cmp_res", dr, 8'h00);
    check("cmp_nvzc", df, 4'b0011);
    run_op(T_ROL, 8'h81, 8'h00, 3'd1, 1'b0, 0, dr, df);
    check("rol_res", dr, 8'h05);
    check("rol_c", df[0], 0);
    run_op(T_ASL, 8'h01, 8'h00, 3'd7, 1'b1, 0, dr, df);
    check("asl_res", dr, 8'h00);
    check("asl_nvzc", df, 4'b0010);
    run_op(T_INC, 8'hFF, 8'h00, 3'd0, 1'b0, 0, dr, df);
    check("inc_res", dr, 8'h00);
    check("inc_nvzc", df, 4'b0010);
    run_op(4'd13, 8'h5A, 8'h33, 3'd0, 1'b1, 5, dr, df);
    check("ill_res", dr, 8'h5A);
    run_op(T_DEC, 8'h00, 8'h00, 3'd0, 1'b0, 0, dr, df);
    check("dec_res", dr, 8'hFF);
    check("dec_nvzc", df, 4'b1000);

    // reset while ROR cnt=7 is on its third step
    @(negedge clk);
    req_valid = 1'b1; req_op = T_ROR; req_a = 8'hC3; req_cnt = 3'd7; req_carry = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_result", rsp_result, 0);
    check("mid_rst_flags", {rsp_flags, rsp_mask, rsp_write, rsp_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    check("mid_rst_ready", req_ready, 1);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = (($urandom_range(0, 9)) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      run_op(op, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), dr, df);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
